// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - drives one DSP48A1 MAC slice through a single-neuron dot product
module mac_sequencer #(
   parameter int ADDR_W  = 10,
   parameter int LEN_W   = 10,
   parameter int MAC_LAT = 2,
   parameter int FRAC    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic [ADDR_W-1:0] w_base,
   input  logic [ADDR_W-1:0] x_base,
   output logic              mem_en,
   output logic [ADDR_W-1:0] w_addr,
   output logic [ADDR_W-1:0] x_addr,
   input  logic [17:0]       w_data,
   input  logic [17:0]       x_data,
   output logic [17:0]       mac_a,
   output logic [17:0]       mac_b,
   output logic              mac_ce,
   output logic              mac_clr,
   input  logic [47:0]       mac_p,
   output logic              busy,
   output logic              done,
   output logic [47:0]       result,
   output logic [17:0]       result_q
);

   // Drain counter spans 0..MAC_LAT; the +2 keeps the width non-zero when MAC_LAT is 0.
   localparam int DR_W = $clog2(MAC_LAT + 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FETCH,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [LEN_W-1:0]  remain;
   logic [DR_W-1:0]   drain_cnt;
   logic              rd_valid;
   logic              clr_run;
   logic              fetch_last;
   logic              drain_last;
   logic signed [47:0] shifted;
   logic [17:0]       sat;

   assign fetch_last = (remain == LEN_W'(1));
   assign drain_last = (drain_cnt == DR_W'(MAC_LAT));

   // The MAC registers are held in reset both by our own reset and by the CLEAR cycle.
   assign mac_clr = clr_run | ~rst;

   // Read data is only meaningful the cycle after a fetch; zero operands add nothing.
   assign mac_a = rd_valid ? x_data : 18'd0;
   assign mac_b = rd_valid ? w_data : 18'd0;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state decode and per-state control strobes.
   always_comb begin
      state_nx = state;
      busy     = 1'b1;
      done     = 1'b0;
      mem_en   = 1'b0;
      mac_ce   = 1'b0;
      clr_run  = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_nx = (len == '0) ? S_DONE : S_CLEAR;
            end
         end
         S_CLEAR: begin
            mac_ce   = 1'b1;
            clr_run  = 1'b1;
            state_nx = S_FETCH;
         end
         S_FETCH: begin
            mem_en = 1'b1;
            mac_ce = 1'b1;
            if (fetch_last) begin
               state_nx = S_DRAIN;
            end
         end
         S_DRAIN: begin
            mac_ce = 1'b1;
            if (drain_last) begin
               state_nx = S_DONE;
            end
         end
         S_DONE: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Scale the accumulator and clamp it into the signed 18-bit activation range.
   always_comb begin
      shifted = $signed(mac_p) >>> FRAC;
      if (shifted > 48'sd131071) begin
         sat = 18'h1FFFF;
      end else if (shifted < -48'sd131072) begin
         sat = 18'h20000;
      end else begin
         sat = shifted[17:0];
      end
   end

   // Run parameters, address generation, read-valid tracking and result capture.
   always_ff @(posedge clk) begin
      if (!rst) begin
         remain    <= '0;
         drain_cnt <= '0;
         rd_valid  <= 1'b0;
         w_addr    <= '0;
         x_addr    <= '0;
         result    <= '0;
         result_q  <= '0;
      end else begin
         rd_valid <= (state == S_FETCH);
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (len == '0) begin
                     result   <= '0;
                     result_q <= '0;
                  end else begin
                     remain <= len;
                     w_addr <= w_base;
                     x_addr <= x_base;
                  end
               end
            end
            S_FETCH: begin
               remain    <= remain - 1'b1;
               w_addr    <= w_addr + 1'b1;
               x_addr    <= x_addr + 1'b1;
               drain_cnt <= '0;
            end
            S_DRAIN: begin
               drain_cnt <= drain_cnt + 1'b1;
               if (drain_last) begin
                  result   <= mac_p;
                  result_q <= sat;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mac_sequencer.sv
// tb/tb_mac_sequencer.sv - scoreboard bench for mac_sequencer with a behavioural MAC and memories
module tb_mac_sequencer;

   localparam int ADDR_W  = 10;
   localparam int LEN_W   = 10;
   localparam int MAC_LAT = 2;
   localparam int FRAC    = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic [LEN_W-1:0]  len = '0;
   logic [ADDR_W-1:0] w_base = '0;
   logic [ADDR_W-1:0] x_base = '0;
   logic              mem_en;
   logic [ADDR_W-1:0] w_addr;
   logic [ADDR_W-1:0] x_addr;
   logic [17:0]       w_data = '0;
   logic [17:0]       x_data = '0;
   logic [17:0]       mac_a;
   logic [17:0]       mac_b;
   logic              mac_ce;
   logic              mac_clr;
   logic [47:0]       mac_p;
   logic              busy;
   logic              done;
   logic [47:0]       result;
   logic [17:0]       result_q;

   mac_sequencer #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W),
      .MAC_LAT(MAC_LAT),
      .FRAC   (FRAC)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .len     (len),
      .w_base  (w_base),
      .x_base  (x_base),
      .mem_en  (mem_en),
      .w_addr  (w_addr),
      .x_addr  (x_addr),
      .w_data  (w_data),
      .x_data  (x_data),
      .mac_a   (mac_a),
      .mac_b   (mac_b),
      .mac_ce  (mac_ce),
      .mac_clr (mac_clr),
      .mac_p   (mac_p),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .result_q(result_q)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [17:0] w_mem [0:1023];
   logic [17:0] x_mem [0:1023];
   always @(posedge clk) begin
      if (mem_en) begin
         w_data <= w_mem[w_addr];
         x_data <= x_mem[x_addr];
      end
   end

   logic signed [35:0] m_reg = '0;
   logic signed [47:0] p_reg = '0;
   assign mac_p = p_reg;
   always @(posedge clk) begin
      if (mac_clr) begin
         m_reg <= '0;
         p_reg <= '0;
      end else if (mac_ce) begin
         m_reg <= $signed(mac_a) * $signed(mac_b);
         p_reg <= p_reg + 48'(m_reg);
      end
   end

   typedef struct {
      logic [47:0] res;
      logic [17:0] q;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   ew_q[$];
   int   ex_q[$];
   int   rst_req = 0;
   bit   fin_req = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   initial begin : monitor
      int   rst_seen;
      exp_t e;
      rst_seen = 0;
      forever begin
         @(negedge clk);
         if (rst_req != rst_seen) begin
            rst_seen = rst_req;
            chk("rst busy", busy, 0);
            chk("rst done", done, 0);
            chk("rst mem_en", mem_en, 0);
            chk("rst mac_ce", mac_ce, 0);
            chk("rst mac_clr", mac_clr, 1);
            chk("rst w_addr", w_addr, 0);
            chk("rst x_addr", x_addr, 0);
            chk("rst mac_a", mac_a, 0);
            chk("rst mac_b", mac_b, 0);
            chk("rst result", result, 0);
            chk("rst result_q", result_q, 0);
         end
         if (mem_en) begin
            if (ew_q.size() == 0) begin
               chk("mem_en extra", mem_en, 0);
            end else begin
               chk("w_addr", w_addr, ew_q.pop_front());
               chk("x_addr", x_addr, ex_q.pop_front());
            end
         end
         if (done) begin
            if (exp_q.size() == 0) begin
               chk("done unexpected", done, 0);
            end else begin
               e = exp_q.pop_front();
               chk("done cycle", cyc, e.cyc);
               chk("result", result, e.res);
               chk("result_q", result_q, e.q);
            end
         end
         if (fin_req) begin
            chk("pending results", exp_q.size(), 0);
            chk("pending reads", ew_q.size(), 0);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
         end
      end
   end

   task automatic push_run(input int n, input int wb, input int xb,
                           input logic [47:0] r, input logic [17:0] q, input int dcyc);
      exp_t e;
      e.res = r;
      e.q   = q;
      e.cyc = dcyc;
      exp_q.push_back(e);
      for (int i = 0; i < n; i++) begin
         ew_q.push_back((wb + i) % 1024);
         ex_q.push_back((xb + i) % 1024);
      end
   endtask

   task automatic run(input int n, input int wb, input int xb,
                      input logic [47:0] r, input logic [17:0] q);
      @(posedge clk); #1;
      len    = LEN_W'(n);
      w_base = ADDR_W'(wb);
      x_base = ADDR_W'(xb);
      start  = 1'b1;
      push_run(n, wb, xb, r, q, (n == 0) ? cyc + 1 : cyc + n + 5);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < budget) begin
         @(posedge clk);
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin : stimulus
      int c;
      for (int i = 0; i < 1024; i++) begin
         w_mem[i] = '0;
         x_mem[i] = '0;
      end
      for (int i = 0; i < 4; i++) begin
         w_mem[i]       = 18'(i + 1);
         x_mem[16 + i]  = 18'(i + 5);
         w_mem[100 + i] = 18'(256 * (i + 1));
         x_mem[200 + i] = 18'(i + 1);
         x_mem[800 + i] = 18'(10 * (i + 1));
      end
      for (int i = 0; i < 8; i++) begin
         w_mem[300 + i] = 18'h1FFFF;
         x_mem[400 + i] = 18'h1FFFF;
         w_mem[500 + i] = 18'h20001;
      end
      w_mem[600]  = 18'h3FFFF;
      x_mem[700]  = 18'd256;
      w_mem[1022] = 18'd3;
      w_mem[1023] = 18'd5;

      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_req++;
      @(negedge clk); #1;
      rst = 1'b1;

      run(4, 0, 16, 48'd70, 18'd0);
      wait_idle(100);
      run(8, 300, 400, 48'sd137436856328, 18'h1FFFF);
      wait_idle(100);
      run(8, 500, 400, -48'sd137436856328, 18'h20000);
      wait_idle(100);
      run(1, 600, 700, -48'sd256, 18'h3FFFF);
      wait_idle(100);
      run(0, 0, 16, 48'd0, 18'd0);
      wait_idle(100);
      run(4, 1022, 800, 48'd240, 18'd0);
      wait_idle(100);

      @(posedge clk); #1;
      len = 10'd4; w_base = 10'd100; x_base = 10'd200; start = 1'b1;
      c = cyc;
      push_run(4, 100, 200, 48'd7680, 18'd30, c + 9);
      push_run(4, 0, 16, 48'd70, 18'd0, c + 19);
      @(posedge clk); #1;
      @(posedge clk); #1;
      len = 10'd4; w_base = 10'd0; x_base = 10'd16;
      repeat (9) @(posedge clk);
      #1;
      start = 1'b0;
      wait_idle(100);

      @(posedge clk); #1;
      len = 10'd10; w_base = 10'd0; x_base = 10'd16; start = 1'b1;
      ew_q.push_back(0); ex_q.push_back(16);
      ew_q.push_back(1); ex_q.push_back(17);
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst_req++;
      @(negedge clk); #1;
      rst = 1'b1;
      repeat (20) @(posedge clk);
      run(2, 0, 16, 48'd17, 18'd0);
      wait_idle(100);

      @(posedge clk); #1;
      len = 10'd3; w_base = 10'd100; x_base = 10'd200; start = 1'b1;
      push_run(3, 100, 200, 48'd3584, 18'd14, cyc + 8);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      len = 10'd4; w_base = 10'd0; x_base = 10'd16; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle(100);
      repeat (15) @(posedge clk);
      #1;

      fin_req = 1'b1;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1);
   end

endmodule
